glyph_blitter: RTL

Parametrised glyph renderer that streams per-pixel x/y/colour/plot writes into the 160x120 vga_adapter pixel port. Generalises the fixed lampboard/wheel drawing loop to NUM_SLOTS glyph slots of arbitrary GLYPH_W x GLYPH_H size, each with its own foreground and background colour. It redraws only slots flagged dirty, and a full pass can be forced. Slot attributes come from external position/bitmap LUTs through a registered select/capture interface. A plot_ready handshake lets an arbiter stall the pixel stream.

---
 rtl/glyph_blitter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/glyph_blitter.sv
// glyph_blitter: redraws dirty glyph slots as a stream of x/y/colour/plot pixel writes.
// Optional build macro GLYPH_TRANSPARENT_EN: background pixels are skipped instead of plotted with slot_bg.
module glyph_blitter #(
    parameter int NUM_SLOTS = 32,
    parameter int SLOT_W    = 5,
    parameter int GLYPH_W   = 5,
    parameter int GLYPH_H   = 5,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOR_W   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_full,
    input  logic [NUM_SLOTS-1:0]       dirty_set,
    output logic [SLOT_W-1:0]          slot_sel,
    input  logic [X_W-1:0]             slot_x,
    input  logic [Y_W-1:0]             slot_y,
    input  logic [GLYPH_W*GLYPH_H-1:0] slot_bitmap,
    input  logic [COLOR_W-1:0]         slot_fg,
    input  logic [COLOR_W-1:0]         slot_bg,
    input  logic                       plot_ready,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [COLOR_W-1:0]         colour,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);

    localparam int PIX_N = GLYPH_W * GLYPH_H;
    localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        LATCH = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [NUM_SLOTS-1:0] dirty_r, dirty_s, clear_mask_s;
    logic [SLOT_W-1:0]    sel_r, sel_s, scan_idx_s;
    logic [X_W-1:0]       base_x_r, base_x_s, x_r, x_s;
    logic [Y_W-1:0]       base_y_r, base_y_s, y_r, y_s;
    logic [PIX_N-1:0]     bits_r, bits_s;
    logic [COLOR_W-1:0]   fg_r, fg_s, bg_r, bg_s, colour_r, colour_s;
    logic [COLOR_W-1:0]   pix_fg_s, pix_bg_s;
    logic [COL_W-1:0]     col_r, col_s;
    logic [ROW_W-1:0]     row_r, row_s;
    logic                 plot_r, plot_s, busy_r, busy_s, done_r, done_s;
    logic                 advance_s, last_pix_s, load_pix_s, pix_bit_s;

    function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
        logic [SLOT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            idx = v[i] ? SLOT_W'(i) : idx;
        end
        return idx;
    endfunction

    // Next-state, dirty bookkeeping and next pixel computation
    always_comb begin
        state_s      = state_r;
        sel_s        = sel_r;
        base_x_s     = base_x_r;
        base_y_s     = base_y_r;
        bits_s       = bits_r;
        fg_s         = fg_r;
        bg_s         = bg_r;
        col_s        = col_r;
        row_s        = row_r;
        x_s          = x_r;
        y_s          = y_r;
        colour_s     = colour_r;
        plot_s       = 1'b0;
        done_s       = 1'b0;
        advance_s    = 1'b0;
        load_pix_s   = 1'b0;
        pix_bit_s    = 1'b0;
        pix_fg_s     = fg_r;
        pix_bg_s     = bg_r;
        scan_idx_s   = lowest_set(dirty_r);
        last_pix_s   = (row_r == ROW_W'(GLYPH_H - 1)) && (col_r == COL_W'(GLYPH_W - 1));

        if ((state_r == SCAN) && (dirty_r != '0)) begin
            clear_mask_s = NUM_SLOTS'(1'b1) << scan_idx_s;
        end else begin
            clear_mask_s = '0;
        end
        // New requests are OR-ed after the clear, so a same-cycle set survives
        dirty_s = (dirty_r & ~clear_mask_s) | dirty_set | {NUM_SLOTS{start_full}};

        case (state_r)
            IDLE: begin
                if (dirty_r != '0) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (dirty_r != '0) begin
                    sel_s   = scan_idx_s;
                    state_s = LATCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LATCH: begin
                base_x_s   = slot_x;
                base_y_s   = slot_y;
                fg_s       = slot_fg;
                bg_s       = slot_bg;
                bits_s     = slot_bitmap << 1'b1;
                col_s      = '0;
                row_s      = '0;
                x_s        = slot_x;
                y_s        = slot_y;
                load_pix_s = 1'b1;
                pix_bit_s  = slot_bitmap[PIX_N-1];
                pix_fg_s   = slot_fg;
                pix_bg_s   = slot_bg;
                state_s    = DRAW;
            end
            DRAW: begin
                plot_s = plot_r;
`ifdef GLYPH_TRANSPARENT_EN
                advance_s = plot_ready | ~plot_r;
`else
                advance_s = plot_ready;
`endif
                if (advance_s && last_pix_s) begin
                    plot_s = 1'b0;
                    if (dirty_s != '0) begin
                        state_s = SCAN;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
                end else if (advance_s) begin
                    if (col_r == COL_W'(GLYPH_W - 1)) begin
                        col_s = '0;
                        row_s = row_r + ROW_W'(1'b1);
                    end else begin
                        col_s = col_r + COL_W'(1'b1);
                        row_s = row_r;
                    end
                    // Coordinates wrap at the port width; the sink clips if it needs to
                    x_s        = base_x_r + X_W'(col_s);
                    y_s        = base_y_r + Y_W'(row_s);
                    bits_s     = bits_r << 1'b1;
                    load_pix_s = 1'b1;
                    pix_bit_s  = bits_r[PIX_N-1];
                end else begin
                    state_s = DRAW;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (load_pix_s) begin
`ifdef GLYPH_TRANSPARENT_EN
            plot_s   = pix_bit_s;
            colour_s = pix_fg_s;
`else
            plot_s   = 1'b1;
            colour_s = pix_bit_s ? pix_fg_s : pix_bg_s;
`endif
        end else begin
            colour_s = colour_s;
        end

        busy_s = (state_s != IDLE);
    end

    // State, slot attribute and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            dirty_r  <= '0;
            sel_r    <= '0;
            base_x_r <= '0;
            base_y_r <= '0;
            bits_r   <= '0;
            fg_r     <= '0;
            bg_r     <= '0;
            col_r    <= '0;
            row_r    <= '0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            dirty_r  <= dirty_s;
            sel_r    <= sel_s;
            base_x_r <= base_x_s;
            base_y_r <= base_y_s;
            bits_r   <= bits_s;
            fg_r     <= fg_s;
            bg_r     <= bg_s;
            col_r    <= col_s;
            row_r    <= row_s;
            x_r      <= x_s;
            y_r      <= y_s;
            colour_r <= colour_s;
            plot_r   <= plot_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign slot_sel = sel_r;
    assign x        = x_r;
    assign y        = y_r;
    assign colour   = colour_r;
    assign plot     = plot_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
